// File: rtl/ifu_fetch.sv
// ifu_fetch: multicycle instruction-fetch unit with a req/ack memory port, next-PC selection and a retired count.
// Optional misaligned-target trap is compiled in with `IFU_ALIGN_CHECK_EN`.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    input  logic        instr_ready,
    input  logic [1:0]  npc_sel,
    input  logic        br_take,
    input  logic [31:0] ext_off,
    input  logic [25:0] j_index,
    input  logic [31:0] jr_addr,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] icount,
    output logic        exc_adel
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic [31:0] icount_r;
    logic        exc_adel_r;
    logic [31:0] pc4_s;
    logic [31:0] next_pc_s;
    logic        accept_s;
    logic        misaligned_s;

    assign pc4_s    = pc_r + 32'd4;
    assign accept_s = (state_r == VALID) && instr_ready;

    // Next-PC selection for the instruction decode is accepting.
    always_comb begin
        next_pc_s = pc4_s;
        case (npc_sel)
            2'd0: next_pc_s = pc4_s;
            2'd1: begin
                if (br_take) begin
                    next_pc_s = pc4_s + ext_off;
                end else begin
                    next_pc_s = pc4_s;
                end
            end
            2'd2:    next_pc_s = {pc4_s[31:28], j_index, 2'b00};
            2'd3:    next_pc_s = jr_addr;
            default: next_pc_s = pc4_s;
        endcase
    end

`ifdef IFU_ALIGN_CHECK_EN
    assign misaligned_s = (next_pc_s[1:0] != 2'b00);
`else
    assign misaligned_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; acks outside FETCH and readies outside VALID are ignored.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: state_nxt_s = FETCH;
            FETCH: begin
                if (im_ack) begin
                    state_nxt_s = VALID;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            VALID: begin
                if (instr_ready) begin
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = VALID;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        im_req      = 1'b0;
        instr_valid = 1'b0;
        case (state_r)
            FETCH:   im_req = 1'b1;
            VALID:   instr_valid = 1'b1;
            default: begin
                im_req      = 1'b0;
                instr_valid = 1'b0;
            end
        endcase
    end

    // PC, fetched word, retired count and trap pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r       <= RESET_PC;
            instr_r    <= 32'h0000_0000;
            icount_r   <= 32'h0000_0000;
            exc_adel_r <= 1'b0;
        end else begin
            exc_adel_r <= 1'b0;
            if ((state_r == FETCH) && im_ack) begin
                instr_r <= im_rdata;
            end
            if (accept_s) begin
                icount_r   <= icount_r + 32'd1;
                exc_adel_r <= misaligned_s;
                if (misaligned_s) begin
                    pc_r <= EXC_VECTOR;
                end else begin
                    pc_r <= next_pc_s & 32'hFFFF_FFFC;
                end
            end
        end
    end

    assign im_addr  = pc_r;
    assign pc       = pc_r;
    assign pc4      = pc4_s;
    assign instr    = instr_r;
    assign icount   = icount_r;
    assign exc_adel = exc_adel_r;

endmodule

// File: tb/tb_ifu_fetch.sv
// Testbench for ifu_fetch: directed scenarios plus random handshakes checked against a transaction-level model.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack = 1'b0;
    logic [31:0] im_rdata = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready = 1'b0;
    logic [1:0]  npc_sel = 2'd0;
    logic        br_take = 1'b0;
    logic [31:0] ext_off = 32'h0;
    logic [25:0] j_index = 26'h0;
    logic [31:0] jr_addr = 32'h0;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] icount;
    logic        exc_adel;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: where the unit is in its fetch/hold cycle, and architectural values.
    bit          m_started;
    bit          m_have;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_icount;
    logic        m_exc;

    ifu_fetch dut (
        .clk(clk), .reset(reset), .im_req(im_req), .im_addr(im_addr),
        .im_ack(im_ack), .im_rdata(im_rdata), .instr_valid(instr_valid),
        .instr(instr), .instr_ready(instr_ready), .npc_sel(npc_sel),
        .br_take(br_take), .ext_off(ext_off), .j_index(j_index),
        .jr_addr(jr_addr), .pc(pc), .pc4(pc4), .icount(icount),
        .exc_adel(exc_adel)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] target_of(input logic [31:0] p);
        logic [31:0] seq;
        seq = p + 32'd4;
        if (npc_sel == 2'd0) return seq;
        if (npc_sel == 2'd1) return br_take ? seq + ext_off : seq;
        if (npc_sel == 2'd2) return {seq[31:28], j_index, 2'b00};
        return jr_addr;
    endfunction

    task automatic model_reset();
        m_started = 1'b0;
        m_have    = 1'b0;
        m_pc      = 32'h0000_3000;
        m_instr   = 32'h0;
        m_icount  = 32'h0;
        m_exc     = 1'b0;
    endtask

    task automatic compare_all();
        check_val("im_req", 32'(im_req), 32'(m_started && !m_have));
        check_val("instr_valid", 32'(instr_valid), 32'(m_have));
        check_val("im_addr", im_addr, m_pc);
        check_val("pc", pc, m_pc);
        check_val("pc4", pc4, m_pc + 32'd4);
        check_val("instr", instr, m_instr);
        check_val("icount", icount, m_icount);
        check_val("exc_adel", 32'(exc_adel), 32'(m_exc));
    endtask

    // Drive one cycle of inputs (at negedge), advance one edge, update the model, check at negedge.
    task automatic step(input logic ack, input logic [31:0] rdata, input logic rdy,
                        input logic [1:0] sel, input logic br, input logic [31:0] off,
                        input logic [25:0] j, input logic [31:0] jr);
        logic [31:0] t;
        im_ack = ack; im_rdata = rdata; instr_ready = rdy;
        npc_sel = sel; br_take = br; ext_off = off; j_index = j; jr_addr = jr;
        @(posedge clk);
        m_exc = 1'b0;
        if (!m_started) begin
            m_started = 1'b1;
        end else if (!m_have) begin
            if (ack) begin
                m_instr = rdata;
                m_have  = 1'b1;
            end
        end else if (rdy) begin
            t = target_of(m_pc);
            m_icount = m_icount + 32'd1;
            m_have   = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
            if (t[1:0] != 2'b00) begin
                m_pc  = 32'h0000_4180;
                m_exc = 1'b1;
            end else begin
                m_pc = t;
            end
`else
            m_pc = {t[31:2], 2'b00};
`endif
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic seq_step(input logic ack, input logic rdy);
        step(ack, $urandom(), rdy, 2'd0, 1'b0, 32'h0, 26'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] held_addr;
        logic [31:0] rnd_off;
        logic [31:0] rnd_jr;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        reset = 1'b0;

        // Back-to-back: ack and ready held high.
        seq_step(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            check_val("b2b_addr", im_addr, 32'h0000_3000 + 32'(4 * k));
            seq_step(1'b1, 1'b1);
            seq_step(1'b1, 1'b1);
            check_val("b2b_icount", icount, 32'(k + 1));
        end
        // pc is 0x300C in FETCH; one more to reach 0x3010.
        seq_step(1'b1, 1'b0);
        seq_step(1'b0, 1'b1);
        check_val("at_3010", pc, 32'h0000_3010);

        // Branch taken backwards, then not taken.
        seq_step(1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 2'd1, 1'b1, 32'hFFFF_FFF8, 26'h0, 32'h0);
        check_val("br_taken", im_addr, 32'h0000_300C);
        seq_step(1'b1, 1'b0);
        seq_step(1'b0, 1'b1);
        seq_step(1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 2'd1, 1'b0, 32'hFFFF_FFF8, 26'h0, 32'h0);
        check_val("br_not_taken", im_addr, 32'h0000_3014);

        // jr back to 0x3000, then j.
        seq_step(1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 2'd3, 1'b0, 32'h0, 26'h0, 32'h0000_3000);
        seq_step(1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 2'd2, 1'b0, 32'h0, 26'h0000C10, 32'h0);
        check_val("jump", pc, 32'h0000_3040);

        // Misaligned jr target.
        seq_step(1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 2'd3, 1'b0, 32'h0, 26'h0, 32'h0000_3002);
`ifdef IFU_ALIGN_CHECK_EN
        check_val("jr_mis_pc", pc, 32'h0000_4180);
        check_val("jr_mis_exc", 32'(exc_adel), 32'd1);
`else
        check_val("jr_mis_pc", pc, 32'h0000_3000);
        check_val("jr_mis_exc", 32'(exc_adel), 32'd0);
`endif
        // Delayed ack: request and address held, ready ignored in FETCH.
        held_addr = im_addr;
        for (int k = 0; k < 3; k++) begin
            seq_step(1'b0, 1'b1);
            check_val("wait_req", 32'(im_req), 32'd1);
            check_val("wait_addr", im_addr, held_addr);
        end
        check_val("exc_one_cycle", 32'(exc_adel), 32'd0);
        step(1'b1, 32'hCAFE_0123, 1'b1, 2'd0, 1'b0, 32'h0, 26'h0, 32'h0);
        check_val("late_instr", instr, 32'hCAFE_0123);
        check_val("late_pc", pc, held_addr);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            rnd_off = $urandom() << 2;
            rnd_jr  = ($urandom_range(0, 7) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
            step(1'(($urandom() & 3) != 0), $urandom(), 1'(($urandom() & 3) != 0),
                 2'($urandom()), 1'($urandom()), rnd_off, 26'($urandom()), rnd_jr);
        end

        // Reset while holding an instruction, with an ack pulse during and after reset.
        while (!instr_valid) seq_step(1'b1, 1'b0);
        seq_step(1'b1, 1'b1);
        step(1'b1, 32'h2408_0005, 1'b0, 2'd0, 1'b0, 32'h0, 26'h0, 32'h0);
        check_val("hold_instr", instr, 32'h2408_0005);
        reset = 1'b1;
        im_ack = 1'b1;
        im_rdata = 32'hDEAD_BEEF;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        im_ack = 1'b0;
        @(negedge clk);
        compare_all();
        reset = 1'b0;
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 2'd0, 1'b0, 32'h0, 26'h0, 32'h0);
        check_val("post_rst_req", 32'(im_req), 32'd1);
        check_val("post_rst_addr", im_addr, 32'h0000_3000);
        check_val("post_rst_instr", instr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Multicycle instruction-fetch unit for the MIPS datapath. It holds the PC, fetches one word per instruction from instruction memory over a req/ack handshake, and presents it to decode. When decode accepts an instruction it computes the next PC. The branch path consumes the 32-bit offset the immediate extender produces in sign-extend-shift-by-2 mode (EOp=3). The unit also keeps a retired-instruction counter.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_3000: PC value on reset.
- `EXC_VECTOR`, default 32'h0000_4180: PC loaded on a misaligned target. Used only when the alignment check is compiled in.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `im_req`, output, 1: fetch request to instruction memory.
- `im_addr`, output, 32: fetch address; equals `pc`.
- `im_ack`, input, 1: memory has `im_rdata` valid this cycle.
- `im_rdata`, input, 32: fetched instruction word.
- `instr_valid`, output, 1: `instr` holds a fetched instruction.
- `instr`, output, 32: fetched instruction.
- `instr_ready`, input, 1: decode accepts `instr` this cycle; `npc_sel`, `br_take`, `ext_off`, `j_index` and `jr_addr` are valid for it.
- `npc_sel`, input, 2: next-PC select. 0 = seq, 1 = branch, 2 = j/jal, 3 = jr.
- `br_take`, input, 1: branch condition (from ALU compare).
- `ext_off`, input, 32: sign-extended offset, already shifted left by 2.
- `j_index`, input, 26: instr[25:0].
- `jr_addr`, input, 32: register-file rs value.
- `pc`, output, 32: address of the current instruction.
- `pc4`, output, 32: `pc`+4, used as the jal link value.
- `icount`, output, 32: retired-instruction count.
- `exc_adel`, output, 1: one-cycle misaligned-target pulse (only with the macro).

## Operation
- Three states: IDLE, FETCH, VALID.
- IDLE:
  - This is the reset state.
  - Go to FETCH on the next clock edge, unconditionally.
- FETCH:
  - `im_req`=1 and `im_addr`=`pc`.
  - On a sampled `im_ack`=1: `instr` <= `im_rdata`, go to VALID.
- VALID:
  - `instr_valid`=1 and `im_req`=0.
  - On `instr_ready`=1: `pc` <= next_pc, `icount` <= `icount`+1, go to FETCH.
  - `im_ack` in this state is ignored.
- `instr_ready` outside VALID is ignored.
- next_pc:
  - sel 0: `pc`+4.
  - sel 1: `br_take` ? `pc`+4+`ext_off` : `pc`+4.
  - sel 2: {`pc4`[31:28], `j_index`, 2'b00}.
  - sel 3: `jr_addr`.
- Arithmetic is 32-bit modulo 2^32; the PC wraps silently.
- `icount` wraps from 32'hFFFF_FFFF to 0.
- Reset values: state IDLE, `pc`=RESET_PC, `instr`=0, `instr_valid`=0, `im_req`=0, `icount`=0, `exc_adel`=0.
- Reset mid-fetch or mid-hold:
  - The in-flight request is abandoned.
  - An `im_ack` arriving during or after reset, before the next FETCH, is ignored.

## Timing
- `pc`, `instr`, `icount` and `exc_adel` are registered.
- `im_req`, `instr_valid`, `im_addr` and `pc4` are decoded from the registered state and `pc`.
- Best case, with `im_ack` in the first FETCH cycle and `instr_ready` in the first VALID cycle, is 2 cycles per instruction.
- After reset deasserts: IDLE for 1 edge, then `im_req` is high from the second cycle.
- `im_addr` is stable for the whole time `im_req` is high.
- `pc` changes only on the edge where VALID and `instr_ready` are both high.
- `pc4` for jal is sampled by decode in the same cycle as `instr_ready`.

## Configuration
- Macro: `IFU_ALIGN_CHECK_EN`.
- Defined:
  - On accept with next_pc[1:0] != 0, `pc` <= EXC_VECTOR.
  - `exc_adel`=1 for exactly the following cycle.
  - `icount` still increments.
- Not defined:
  - `pc` <= {next_pc[31:2], 2'b00}.
  - `exc_adel` is tied to 0.

## Test plan
- Reset, then `im_ack` held high and `instr_ready` held high:
  - `im_addr` sequence is 0x3000, 0x3004, 0x3008 on every second cycle.
  - `icount` is 1, 2, 3.
- Accept with sel 1, `br_take`=1, `ext_off`=0xFFFF_FFF8 at `pc`=0x3010:
  - next `im_addr`=0x300C.
  - With `br_take`=0 instead: 0x3014.
- Accept with sel 2, `j_index`=0x0000C10 at `pc`=0x3000: next `pc`=0x0000_3040.
- Accept with sel 3, `jr_addr`=0x3002:
  - With the macro: `pc`=0x4180 and a one-cycle `exc_adel` pulse.
  - Without the macro: `pc`=0x3000.
- Memory delays `im_ack` by 3 cycles:
  - `im_req` and `im_addr` stay stable for 3 cycles.
  - `instr` updates one edge after the ack.
  - `instr_ready` while in FETCH has no effect.
- Assert `reset` while in VALID with `instr`=0x2408_0005, and pulse `im_ack` during reset:
  - All outputs return to their reset values.
  - First `im_req` after release is at 0x3000.
